toggle_gen_multi: RTL and testbench

//   Parametrised multi-channel toggle generator: NUM_CH independent square-wave outputs, each

---
 rtl/toggle_gen_multi.sv | 112 +++++++++++
 tb/tb_toggle_gen_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_gen_multi.sv
// Multi-channel square-wave generator with per-channel programmable half-period, enable and global re-align.
// Optional macro TOGGLE_GEN_PULSE_EN adds a registered one-cycle strobe per toggle on edge_pulse.
module toggle_gen_multi #(
    parameter int   NUM_CH    = 4,
    parameter int   CNT_W     = 8,
    parameter logic RST_LEVEL = 1'b0,
    localparam int  CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] out_signal,
    output logic [NUM_CH-1:0] edge_pulse
);

    // Config handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready.
    // cfg_ready is low only while the addressed channel already holds an unapplied value.

    logic [CNT_W-1:0]  cnt_q       [NUM_CH];
    logic [CNT_W-1:0]  half_q      [NUM_CH];
    logic [CNT_W-1:0]  pend_half_q [NUM_CH];
    logic [NUM_CH-1:0] pend_v_q;
    logic [NUM_CH-1:0] out_q;
    logic [NUM_CH-1:0] tog;
    logic              ch_in_range;
    logic              accept;

    always_comb begin
        cfg_ready   = 1'b1;
        ch_in_range = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready   = ~pend_v_q[i];
                ch_in_range = 1'b1;
            end
        end
    end

    assign accept = cfg_valid & cfg_ready;

    // A toggle is a real level change; the sync_start reload is not one.
    always_comb begin
        tog = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tog[i] = ~sync_start & en[i] & (cnt_q[i] == half_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]       <= '0;
                half_q[i]      <= '0;
                pend_half_q[i] <= '0;
            end
            pend_v_q <= '0;
            out_q    <= {NUM_CH{RST_LEVEL}};
            cfg_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_start || !en[i] || tog[i]) begin
                    // Every cnt==0 point is a safe place to switch half-period.
                    cnt_q[i] <= '0;
                    if (pend_v_q[i]) begin
                        half_q[i]   <= pend_half_q[i];
                        pend_v_q[i] <= 1'b0;
                    end
                    if (sync_start) begin
                        out_q[i] <= RST_LEVEL;
                    end else if (tog[i]) begin
                        out_q[i] <= ~out_q[i];
                    end
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
                // A new accept only happens when pend_v is clear, so it never races the apply above.
                if (accept && cfg_ch == CH_W'(i)) begin
                    pend_half_q[i] <= cfg_half;
                    pend_v_q[i]    <= 1'b1;
                end
            end
            if (accept && !ch_in_range) begin
                cfg_err <= 1'b1;
            end
        end
    end

    assign out_signal = out_q;

`ifdef TOGGLE_GEN_PULSE_EN
    logic [NUM_CH-1:0] pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= tog;
        end
    end

    assign edge_pulse = pulse_q;
`else
    assign edge_pulse = '0;
`endif

endmodule

// File: tb/tb_toggle_gen_multi.sv
// Directed bench for toggle_gen_multi: main 4-channel instance plus a 3-channel instance for the
// out-of-range config path.
module tb_toggle_gen_multi;

`ifdef TOGGLE_GEN_PULSE_EN
    localparam bit PULSE_ON = 1'b1;
`else
    localparam bit PULSE_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] en;
    logic       sync_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_half;
    logic       cfg_err;
    logic [3:0] out_signal;
    logic [3:0] edge_pulse;

    logic [2:0] en3;
    logic       cfg_valid3;
    logic       cfg_ready3;
    logic [1:0] cfg_ch3;
    logic [7:0] cfg_half3;
    logic       cfg_err3;
    logic [2:0] out3;
    logic [2:0] pulse3;

    int n_tests = 0;
    int n_fail  = 0;

    toggle_gen_multi #(.NUM_CH(4), .CNT_W(8), .RST_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_start(sync_start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_half(cfg_half),
        .cfg_err(cfg_err), .out_signal(out_signal), .edge_pulse(edge_pulse)
    );

    toggle_gen_multi #(.NUM_CH(3), .CNT_W(8), .RST_LEVEL(1'b0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .sync_start(sync_start),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3), .cfg_half(cfg_half3),
        .cfg_err(cfg_err3), .out_signal(out3), .edge_pulse(pulse3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic [3:0] o, input logic [3:0] p);
        check(tag, 32'(out_signal), 32'(o));
        check({tag, "_pulse"}, 32'(edge_pulse), PULSE_ON ? 32'(p) : 32'd0);
    endtask

    initial begin
        logic [3:0] exp_o;
        logic [3:0] exp_p;
        logic       b;

        rst_n = 1'b0; en = '0; sync_start = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
        en3 = '0; cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_half3 = '0;

        // reset state, then ch0 at half=0 toggles every cycle
        repeat (2) tick();
        expect_outs("rst", 4'b0000, 4'b0000);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        en    = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            expect_outs($sformatf("c1_k%0d", k), {3'b000, k[0]}, 4'b0001);
        end
        en = 4'b0000;
        tick();
        expect_outs("c1_frozen", 4'b0000, 4'b0000);

        // ch1 half=3 -> period 8
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd3;
        check("c2_ready_idle", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        check("c2_ready_pend", 32'(cfg_ready), 32'd0);
        tick();
        check("c2_ready_applied", 32'(cfg_ready), 32'd1);
        en = 4'b0010;
        for (int k = 1; k <= 16; k++) begin
            tick();
            b     = ((k / 4) % 2) == 1;
            exp_o = {2'b00, b, 1'b0};
            exp_p = (k % 4 == 0) ? 4'b0010 : 4'b0000;
            expect_outs($sformatf("c2_k%0d", k), exp_o, exp_p);
        end

        // ch1 half 3->1 written at cnt=1; second write stalls until the boundary
        for (int k = 17; k <= 26; k++) begin
            if (k == 18) begin
                cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd1;
                check("c3_ready_first", 32'(cfg_ready), 32'd1);
            end
            if (k == 22) cfg_valid = 1'b0;
            tick();
            b     = (k == 20 || k == 21 || k == 24 || k == 25);
            exp_o = {2'b00, b, 1'b0};
            exp_p = (k == 20 || k == 22 || k == 24 || k == 26) ? 4'b0010 : 4'b0000;
            expect_outs($sformatf("c3_k%0d", k), exp_o, exp_p);
            if (k == 18 || k == 19) check($sformatf("c3_stall_k%0d", k), 32'(cfg_ready), 32'd0);
            if (k == 20) check("c3_ready_boundary", 32'(cfg_ready), 32'd1);
        end
        en = 4'b0000;

        // ch0 half=0, ch2 half=5, then sync_start re-aligns
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd5;
        tick();
        cfg_valid = 1'b0;
        tick();
        en = 4'b0101;
        repeat (3) tick();
        expect_outs("c4_pre", 4'b0001, 4'b0001);
        sync_start = 1'b1;
        tick();
        sync_start = 1'b0;
        expect_outs("c4_sync", 4'b0000, 4'b0000);
        for (int j = 1; j <= 12; j++) begin
            tick();
            b     = ((j / 6) % 2) == 1;
            exp_o = {1'b0, b, 1'b0, j[0]};
            exp_p = {1'b0, (j % 6 == 0), 1'b0, 1'b1};
            expect_outs($sformatf("c4_j%0d", j), exp_o, exp_p);
        end

        // reset mid-period with a pending update on ch2
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd2;
        tick();
        cfg_valid = 1'b0;
        check("c6_pend", 32'(cfg_ready), 32'd0);
        check("c6_pre_out", 32'(out_signal), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("c6_async_out", 32'(out_signal), 32'h0);
        check("c6_async_ready", 32'(cfg_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        en    = 4'b0100;
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_outs($sformatf("c6_k%0d", k), {1'b0, k[0], 2'b00}, 4'b0100);
        end
        check("c6_err", 32'(cfg_err), 32'd0);
        en = 4'b0000;

        // 3-channel build: ch=3 is out of range
        check("c5_err_init", 32'(cfg_err3), 32'd0);
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_half3 = 8'($urandom_range(1, 255));
        check("c5_ready_oor", 32'(cfg_ready3), 32'd1);
        tick();
        cfg_valid3 = 1'b0;
        check("c5_err_set", 32'(cfg_err3), 32'd1);
        check("c5_out_idle", 32'(out3), 32'd0);
        check("c5_ready_after", 32'(cfg_ready3), 32'd1);
        en3 = 3'b001;
        tick();
        check("c5_ch0_t1", 32'(out3), 32'd1);
        tick();
        check("c5_ch0_t2", 32'(out3), 32'd0);
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd0; cfg_half3 = 8'd2;
        tick();
        cfg_valid3 = 1'b0;
        check("c5_err_sticky", 32'(cfg_err3), 32'd1);
        en3 = 3'b000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
